can_frame_rx: RTL and testbench
===============================

// Module: can_frame_rx
// PURPOSE
//  Receive half of a custom CAN node. Samples the single-ended bus level and recovers bit timing.
//  Removes stuff bits, checks CRC-15 and parses CAN 2.0A standard frames.
//  Drives the ACK slot and presents each accepted frame to the node logic.
//  Sits between the bus input pins and the node controller; the frame transmitter is a separate block.
// PARAMETERS
//  BIT_TICKS     16   clk cycles per CAN bit (>=8)
//  SAMPLE_POINT  11   counter value at which a bit is sampled (1..BIT_TICKS-2)
// PORTS
//  clk          in   1   sole clock
//  rst_n        in   1   asynchronous active-low reset
//  can_rx       in   1   bus level, 0=dominant, asynchronous to clk
//  filter_id    in   11  acceptance ID
//  filter_mask  in   11  1=bit compared; frame accepted iff (id^filter_id)&filter_mask==0
//  tx_ack       out  1   0=drive dominant in ACK slot, else 1
//  rx_valid     out  1   one-clk pulse, frame accepted
//  rx_id        out  11  frame ID
//  rx_rtr       out  1   remote request flag
//  rx_dlc       out  4   DLC as received
//  rx_data      out  64  first byte in [63:56]; bytes beyond min(DLC,8) are zero
//  err_stuff    out  1   one-clk pulse, stuff error
//  err_crc      out  1   one-clk pulse, CRC mismatch
//  err_form     out  1   one-clk pulse, form error (IDE=1, recessive bit expected but dominant)
//  busy         out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (any time, mid-frame included): all outputs 0 except tx_ack=1; state IDLE; counters cleared.
//  Input path
//   - can_rx goes through a 2-flop synchroniser; all timing below refers to the synchronised signal.
//  Bit timer
//   - Counter runs 0..BIT_TICKS-1 and wraps.
//   - In IDLE, a 1->0 edge forces the counter to 0 (hard sync).
//   - In the frame, every 1->0 edge forces the counter to 0 (resync).
//   - Bit sampled when counter==SAMPLE_POINT.
//  Destuffing
//   - Active from SOF through the last CRC bit.
//   - After 5 equal sampled bits, the next bit is a stuff bit: discarded, not CRC'd.
//   - A stuff bit equal to the previous bit -> err_stuff.
//  CRC-15
//   - Polynomial 0x4599, init 0.
//   - Covers SOF..last data bit.
//   - Compared with the 15 received CRC bits.
//  States and transitions, advanced on each non-stuff sample:
//   - IDLE: sampled 0 = SOF -> ARB.
//   - ARB: 11 ID bits MSB first, then RTR -> CTRL.
//   - CTRL: IDE (must be 0 else err_form), r0, DLC[3:0].
//     Leaves to DATA, or to CRC when RTR=1 or DLC=0.
//   - DATA: 8*min(DLC,8) bits -> CRC.
//   - CRC: 15 bits -> CRC_DLM.
//   - CRC_DLM: must sample 1 else err_form.
//     If CRC mismatch: err_crc, -> ERROR.
//     Else -> ACK.
//   - ACK: tx_ack=0 from the counter wrap after the CRC_DLM sample until the next wrap.
//     Exactly BIT_TICKS clks; only when the ID filter matches, else tx_ack stays 1.
//     Sampled value ignored.
//   - ACK_DLM: must be 1 else err_form.
//   - EOF: 7 bits, all must be 1 else err_form.
//     At the 7th EOF sample, if the filter matched:
//       rx_valid pulses and rx_id/rx_rtr/rx_dlc/rx_data update in the same clk.
//     Then -> IDLE.
//   - ERROR: error pulse issued on entry (one clk); tx_ack=1.
//     Stays until 11 consecutive recessive samples, then -> IDLE.
//  Error priority
//   - At most one error pulse per frame; first detected wins.
//   - Parsing stops at the first error.
//  Output holding
//   - rx_* outputs hold between accepted frames.
//   - Never altered by rejected or errored frames.
// TESTING
//  1. ID 0x123, RTR 0, DLC 2, data A5 5A, valid CRC, filter_id 0x123/mask 0x7FF:
//     -> tx_ack low exactly 16 clks in ACK slot.
//     -> one rx_valid; rx_data=64'hA55A000000000000.
//  2. Same frame, filter_id 0x124, mask 0x7FF:
//     -> tx_ack stays 1, no rx_valid, rx_* unchanged.
//  3. Frame 1 with one CRC bit flipped (stuffing kept legal):
//     -> err_crc pulse once, no ack, no rx_valid, back to IDLE after 11 recessive bits.
//  4. Six consecutive dominant bits inside the ID:
//     -> err_stuff pulse; busy stays 1 until 11 recessive bits.
//  5. RTR=1, DLC=4, ID 0x7F0:
//     -> no data bits parsed; rx_valid, rx_dlc=4, rx_data=0.
//  6. rst_n low mid-DATA, then release and send frame 1:
//     -> outputs at reset values during reset, frame 1 then received correctly.

Source files
------------

// File: rtl/can_frame_rx.sv
// CAN 2.0A standard-frame receiver: bit timing, destuffing, CRC-15,
// acceptance filtering and ACK-slot drive.
module can_frame_rx #(
    parameter int BIT_TICKS    = 16,
    parameter int SAMPLE_POINT = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        can_rx,
    input  logic [10:0] filter_id,
    input  logic [10:0] filter_mask,
    output logic        tx_ack,
    output logic        rx_valid,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        err_stuff,
    output logic        err_crc,
    output logic        err_form,
    output logic        busy
);

    localparam int CW = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] SP   = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC,
        S_CRC_DLM, S_ACK, S_ACK_DLM, S_EOF, S_ERROR
    } state_t;

    state_t r_state, w_state_nxt;

    logic          r_sync1, r_sync2, r_rx_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_ack_cnt;
    logic          r_tx_ack;
    logic [2:0]    r_stuff_cnt;
    logic          r_last_bit;
    logic [6:0]    r_bitcnt;
    logic [6:0]    r_nbits;
    logic [3:0]    r_rec_cnt;
    logic [14:0]   r_crc, r_crc_rx;
    logic [10:0]   r_id;
    logic          r_rtr;
    logic [3:0]    r_dlc;
    logic [63:0]   r_data;
    logic          r_rx_valid, r_rx_rtr;
    logic [10:0]   r_rx_id;
    logic [3:0]    r_rx_dlc;
    logic [63:0]   r_rx_data;
    logic          r_err_stuff, r_err_crc, r_err_form;

    logic          w_bit, w_fall, w_wrap, w_samp;
    logic          w_in_stuff, w_is_stuff, w_nb, w_match;
    logic [3:0]    w_dlc_new;
    logic [14:0]   w_crc_nxt;
    logic          w_err_stuff, w_err_crc, w_err_form, w_accept;

    function automatic logic [14:0] crc_step(input logic [14:0] c,
                                             input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    assign w_bit      = r_sync2;
    assign w_fall     = r_rx_prev & ~r_sync2;
    assign w_wrap     = w_fall | (r_cnt == LAST);
    assign w_samp     = (r_cnt == SP) && !w_fall;
    assign w_in_stuff = r_state inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DLM};
    assign w_is_stuff = w_samp && w_in_stuff && (r_stuff_cnt == 3'd5);
    assign w_nb       = w_samp && !w_is_stuff;
    assign w_match    = ((r_id ^ filter_id) & filter_mask) == 11'd0;
    assign w_dlc_new  = {r_dlc[2:0], w_bit};
    assign w_crc_nxt  = crc_step(r_crc, w_bit);

    assign tx_ack    = r_tx_ack;
    assign rx_valid  = r_rx_valid;
    assign rx_id     = r_rx_id;
    assign rx_rtr    = r_rx_rtr;
    assign rx_dlc    = r_rx_dlc;
    assign rx_data   = r_rx_data;
    assign err_stuff = r_err_stuff;
    assign err_crc   = r_err_crc;
    assign err_form  = r_err_form;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= can_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_stuff = 1'b0;
        w_err_crc   = 1'b0;
        w_err_form  = 1'b0;
        w_accept    = 1'b0;
        if (w_is_stuff) begin
            if (w_bit == r_last_bit) begin
                w_err_stuff = 1'b1;
                w_state_nxt = S_ERROR;
            end
        end else if (w_nb) begin
            unique case (r_state)
                S_IDLE: if (!w_bit) w_state_nxt = S_ARB;
                S_ARB:  if (r_bitcnt == 7'd11) w_state_nxt = S_CTRL;
                S_CTRL: begin
                    if (r_bitcnt == 7'd0 && w_bit) begin
                        w_err_form  = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else if (r_bitcnt == 7'd5) begin
                        if (r_rtr || w_dlc_new == 4'd0) w_state_nxt = S_CRC;
                        else                            w_state_nxt = S_DATA;
                    end
                end
                S_DATA: if (r_bitcnt == r_nbits - 7'd1) w_state_nxt = S_CRC;
                S_CRC:  if (r_bitcnt == 7'd14) w_state_nxt = S_CRC_DLM;
                S_CRC_DLM: begin
                    if (!w_bit) begin
                        w_err_form  = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else if (r_crc_rx != r_crc) begin
                        w_err_crc   = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_ACK;
                    end
                end
                S_ACK: w_state_nxt = S_ACK_DLM;
                S_ACK_DLM: begin
                    if (!w_bit) begin
                        w_err_form  = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_EOF;
                    end
                end
                S_EOF: begin
                    if (!w_bit) begin
                        w_err_form  = 1'b1;
                        w_state_nxt = S_ERROR;
                    end else if (r_bitcnt == 7'd6) begin
                        w_accept    = w_match;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ERROR: if (w_bit && r_rec_cnt == 4'd10) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ack    <= 1'b1;
            r_ack_cnt   <= '0;
            r_stuff_cnt <= '0;
            r_last_bit  <= 1'b1;
            r_bitcnt    <= '0;
            r_nbits     <= '0;
            r_rec_cnt   <= '0;
            r_crc       <= '0;
            r_crc_rx    <= '0;
            r_id        <= '0;
            r_rtr       <= 1'b0;
            r_dlc       <= '0;
            r_data      <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_id     <= '0;
            r_rx_rtr    <= 1'b0;
            r_rx_dlc    <= '0;
            r_rx_data   <= '0;
            r_err_stuff <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_form  <= 1'b0;
        end else begin
            r_err_stuff <= w_err_stuff;
            r_err_crc   <= w_err_crc;
            r_err_form  <= w_err_form;
            r_rx_valid  <= w_accept;
            if (w_accept) begin
                r_rx_id   <= r_id;
                r_rx_rtr  <= r_rtr;
                r_rx_dlc  <= r_dlc;
                r_rx_data <= r_data;
            end
            // ACK drive is timed by its own counter so resync cannot stretch it
            if (!r_tx_ack) begin
                if (r_ack_cnt == '0) r_tx_ack <= 1'b1;
                else                 r_ack_cnt <= r_ack_cnt - 1'b1;
            end else if (r_state == S_ACK && w_wrap && w_match) begin
                r_tx_ack  <= 1'b0;
                r_ack_cnt <= LAST;
            end
            if (w_state_nxt != r_state)
                r_bitcnt <= '0;
            else if (w_nb && r_state != S_IDLE)
                r_bitcnt <= r_bitcnt + 7'd1;
            if (r_state != S_ERROR)
                r_rec_cnt <= '0;
            else if (w_samp)
                r_rec_cnt <= w_bit ? r_rec_cnt + 4'd1 : 4'd0;
            if (r_state == S_IDLE && w_state_nxt == S_ARB) begin
                r_last_bit  <= 1'b0;
                r_stuff_cnt <= 3'd1;
                r_crc       <= '0;
                r_crc_rx    <= '0;
                r_id        <= '0;
                r_rtr       <= 1'b0;
                r_dlc       <= '0;
                r_data      <= '0;
                r_nbits     <= '0;
            end else if (w_is_stuff) begin
                r_last_bit  <= w_bit;
                r_stuff_cnt <= 3'd1;
            end else if (w_nb && w_in_stuff) begin
                r_last_bit  <= w_bit;
                r_stuff_cnt <= (w_bit == r_last_bit) ? r_stuff_cnt + 3'd1 : 3'd1;
                unique case (r_state)
                    S_ARB: begin
                        r_crc <= w_crc_nxt;
                        if (r_bitcnt == 7'd11) r_rtr <= w_bit;
                        else                   r_id  <= {r_id[9:0], w_bit};
                    end
                    S_CTRL: begin
                        r_crc <= w_crc_nxt;
                        if (r_bitcnt >= 7'd2) r_dlc <= w_dlc_new;
                        if (r_bitcnt == 7'd5)
                            r_nbits <= w_dlc_new[3] ? 7'd64
                                                    : {1'b0, w_dlc_new[2:0], 3'b000};
                    end
                    S_DATA: begin
                        r_crc <= w_crc_nxt;
                        r_data[6'd63 - r_bitcnt[5:0]] <= w_bit;
                    end
                    S_CRC: r_crc_rx <= {r_crc_rx[13:0], w_bit};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: table of whole frames plus
// hand sequences for stuff/form errors and mid-frame reset.
module tb_can_frame_rx;

    logic        clk;
    logic        rst_n;
    logic        can_rx;
    logic [10:0] filter_id;
    logic [10:0] filter_mask;
    logic        tx_ack;
    logic        rx_valid;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        err_stuff;
    logic        err_crc;
    logic        err_form;
    logic        busy;

    can_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .can_rx      (can_rx),
        .filter_id   (filter_id),
        .filter_mask (filter_mask),
        .tx_ack      (tx_ack),
        .rx_valid    (rx_valid),
        .rx_id       (rx_id),
        .rx_rtr      (rx_rtr),
        .rx_dlc      (rx_dlc),
        .rx_data     (rx_data),
        .err_stuff   (err_stuff),
        .err_crc     (err_crc),
        .err_form    (err_form),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic [10:0] fid;
        logic [10:0] fmask;
        int          flip;
        logic        ok;
        int          acks;
        int          ecrc;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tbl[7];
    logic q_bits[$];

    int n_chk = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ack = 0;
    int n_estuff = 0;
    int n_ecrc = 0;
    int n_eform = 0;

    logic [10:0] e_id;
    logic        e_rtr;
    logic [3:0]  e_dlc;
    logic [63:0] e_data;

    always @(negedge clk) begin
        if (rx_valid)  n_valid++;
        if (!tx_ack)   n_ack++;
        if (err_stuff) n_estuff++;
        if (err_crc)   n_ecrc++;
        if (err_form)  n_eform++;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] crc_upd(input logic [14:0] c,
                                            input logic b);
        logic [15:0] t;
        t = {c, 1'b0};
        if (b ^ c[14]) t[14:0] = t[14:0] ^ 15'h4599;
        return t[14:0];
    endfunction

    task automatic build_frame(input logic [10:0] id, input logic rtr,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input int flip, input logic ack_dom);
        logic        raw[$];
        logic [14:0] crc;
        int          nb;
        int          run;
        logic        last;
        raw.delete();
        q_bits.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : (dlc > 4'd8 ? 64 : int'(dlc) * 8);
        for (int i = 0; i < nb; i++) raw.push_back(data[63 - i]);
        crc = '0;
        foreach (raw[i]) crc = crc_upd(crc, raw[i]);
        if (flip >= 0) crc[flip] = ~crc[flip];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        run  = 0;
        last = 1'b1;
        foreach (raw[i]) begin
            q_bits.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin
                run  = 1;
                last = raw[i];
            end
            if (run == 5) begin
                q_bits.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        q_bits.push_back(1'b1);
        q_bits.push_back(~ack_dom);
        q_bits.push_back(1'b1);
        for (int i = 0; i < 10; i++) q_bits.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b);
        can_rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n && i < q_bits.size(); i++) send_bit(q_bits[i]);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic clr_counts();
        n_valid  = 0;
        n_ack    = 0;
        n_estuff = 0;
        n_ecrc   = 0;
        n_eform  = 0;
    endtask

    task automatic chk_held(input string tag);
        chk({tag, " rx_id"},   64'(rx_id),  64'(e_id));
        chk({tag, " rx_rtr"},  64'(rx_rtr), 64'(e_rtr));
        chk({tag, " rx_dlc"},  64'(rx_dlc), 64'(e_dlc));
        chk({tag, " rx_data"}, rx_data,     e_data);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " busy"},     64'(busy),     64'd0);
        chk({tag, " tx_ack"},   64'(tx_ack),   64'd1);
        chk({tag, " rx_valid"}, 64'(rx_valid), 64'd0);
        chk({tag, " rx_id"},    64'(rx_id),    64'd0);
        chk({tag, " rx_rtr"},   64'(rx_rtr),   64'd0);
        chk({tag, " rx_dlc"},   64'(rx_dlc),   64'd0);
        chk({tag, " rx_data"},  rx_data,       64'd0);
        chk({tag, " errs"},     64'({err_stuff, err_crc, err_form}), 64'd0);
    endtask

    initial begin
        tbl[0] = '{11'h123, 1'b0, 4'd2,  64'hA55A_0000_0000_0000, 11'h123, 11'h7FF,
                   -1, 1'b1, 16, 0, 64'hA55A_0000_0000_0000};
        tbl[1] = '{11'h123, 1'b0, 4'd2,  64'hA55A_0000_0000_0000, 11'h124, 11'h7FF,
                   -1, 1'b0, 0,  0, 64'h0};
        tbl[2] = '{11'h123, 1'b0, 4'd2,  64'hA55A_0000_0000_0000, 11'h123, 11'h7FF,
                   3,  1'b0, 0,  1, 64'h0};
        tbl[3] = '{11'h7F0, 1'b1, 4'd4,  64'hDEAD_BEEF_0000_0000, 11'h7F0, 11'h7FF,
                   -1, 1'b1, 16, 0, 64'h0};
        tbl[4] = '{11'h000, 1'b0, 4'd8,  64'h0123_4567_89AB_CDEF, 11'h000, 11'h7FF,
                   -1, 1'b1, 16, 0, 64'h0123_4567_89AB_CDEF};
        tbl[5] = '{11'h555, 1'b0, 4'd15, 64'hFFFF_0000_FFFF_0000, 11'h550, 11'h7F0,
                   -1, 1'b1, 16, 0, 64'hFFFF_0000_FFFF_0000};
        tbl[6] = '{11'h3FF, 1'b0, 4'd0,  64'hDEAD_BEEF_CAFE_F00D, 11'h000, 11'h000,
                   -1, 1'b1, 16, 0, 64'h0};

        e_id   = '0;
        e_rtr  = 1'b0;
        e_dlc  = '0;
        e_data = '0;

        can_rx      = 1'b1;
        rst_n       = 1'b0;
        filter_id   = 11'h123;
        filter_mask = 11'h7FF;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;
        send_idle(3);

        for (int i = 0; i < 7; i++) begin
            filter_id   = tbl[i].fid;
            filter_mask = tbl[i].fmask;
            clr_counts();
            build_frame(tbl[i].id, tbl[i].rtr, tbl[i].dlc, tbl[i].data,
                        tbl[i].flip, tbl[i].acks > 0);
            send_bits(q_bits.size());
            send_idle(11);
            if (tbl[i].ok) begin
                e_id   = tbl[i].id;
                e_rtr  = tbl[i].rtr;
                e_dlc  = tbl[i].dlc;
                e_data = tbl[i].exp_data;
            end
            chk($sformatf("v%0d valid", i),     64'(n_valid),  64'(tbl[i].ok));
            chk($sformatf("v%0d ack_lows", i),  64'(n_ack),    64'(tbl[i].acks));
            chk($sformatf("v%0d err_crc", i),   64'(n_ecrc),   64'(tbl[i].ecrc));
            chk($sformatf("v%0d err_stuff", i), 64'(n_estuff), 64'd0);
            chk($sformatf("v%0d err_form", i),  64'(n_eform),  64'd0);
            chk($sformatf("v%0d busy", i),      64'(busy),     64'd0);
            chk_held($sformatf("v%0d", i));
        end

        // six dominant bits inside the ID
        filter_id   = 11'h123;
        filter_mask = 11'h7FF;
        clr_counts();
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        send_idle(10);
        chk("stuff busy10", 64'(busy), 64'd1);
        send_idle(1);
        chk("stuff busy11", 64'(busy), 64'd0);
        chk("stuff err_stuff", 64'(n_estuff), 64'd1);
        chk("stuff others", 64'(n_ecrc + n_eform + n_valid + n_ack), 64'd0);
        chk_held("stuff");

        // IDE recessive in a standard frame
        clr_counts();
        send_bit(1'b0);
        for (int i = 0; i < 11; i++) send_bit(i[0]);
        send_bit(1'b1);
        send_bit(1'b1);
        send_idle(11);
        chk("ide err_form", 64'(n_eform), 64'd1);
        chk("ide others", 64'(n_ecrc + n_estuff + n_valid + n_ack), 64'd0);
        chk("ide busy", 64'(busy), 64'd0);

        // reset in the middle of the data field
        clr_counts();
        build_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1, 1'b1);
        send_bits(30);
        chk("mid busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        can_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("midrst");
        rst_n = 1'b1;
        send_idle(3);
        clr_counts();
        send_bits(q_bits.size());
        send_idle(11);
        e_id   = 11'h123;
        e_rtr  = 1'b0;
        e_dlc  = 4'd2;
        e_data = 64'hA55A_0000_0000_0000;
        chk("post valid", 64'(n_valid), 64'd1);
        chk("post ack_lows", 64'(n_ack), 64'd16);
        chk("post errs", 64'(n_ecrc + n_estuff + n_eform), 64'd0);
        chk_held("post");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
